// File: rtl/ndma_pkg.sv
// Shared NanoDMA definitions: write FSM state encoding, OBI byte-enable
// for full-word writes, and transfer length width.
package ndma_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [3:0]  OBI_BE_WORD = 4'hF;
    localparam int unsigned NDMA_LEN_W  = 16;
endpackage

// File: rtl/ndma_write_mgr_if.sv
// OBI address/response channel bundle shared by NanoDMA managers and the
// memory-side subordinates.
interface OBI_BUS;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic [0:0]  a_optional;
    logic        rvalid;
    logic        err;

    modport Manager (
        output req, addr, we, be, wdata, aid, a_optional,
        input  gnt, rvalid, err
    );
    modport Subordinate (
        input  req, addr, we, be, wdata, aid, a_optional,
        output gnt, rvalid, err
    );
endinterface

// File: rtl/ndma_fifo.sv
// Synchronous power-of-two FIFO with first-word head output; pushes while
// full and pops while empty are dropped.
module ndma_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == DEPTH_C);
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end
endmodule

// File: rtl/ndma_write_mgr.sv
// NanoDMA write manager: buffers read-side words and issues one OBI write per
// word to incrementing addresses. Define NDMA_WR_ERR_EN for a sticky err_o.
module ndma_write_mgr
    import ndma_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [31:0]           dst_addr_i,
    input  logic [NDMA_LEN_W-1:0] len_i,
    input  logic [31:0]           data_i,
    input  logic                  data_valid_i,
    output logic                  full_o,
    output logic                  busy_o,
    output logic                  done_o,
`ifdef NDMA_WR_ERR_EN
    output logic                  err_o,
`endif
    OBI_BUS.Manager               write_mgr
);
    state_t                state;
    logic [31:0]           cur_addr;
    logic [NDMA_LEN_W-1:0] remaining;
    logic                  done_zero;
    logic [31:0]           head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  req;
    logic                  hs;
    logic                  rsp;
    logic                  last_rsp;

    ndma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (data_valid_i),
        .data_i  (data_i),
        .pop_i   (hs),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // req follows FIFO occupancy; the head cannot change until the pop, so
    // addr/wdata stay stable across a grant stall without extra holding regs.
    assign req      = (state == REQ) && !fifo_empty;
    assign hs       = req && write_mgr.gnt;
    assign rsp      = (state == RESP) && write_mgr.rvalid;
    assign last_rsp = rsp && (remaining == NDMA_LEN_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            done_zero <= 1'b0;
        end else begin
            done_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        cur_addr  <= dst_addr_i;
                        remaining <= len_i;
                        if (len_i == '0) done_zero <= 1'b1;
                        else             state     <= REQ;
                    end
                end
                REQ: begin
                    if (hs) state <= RESP;
                end
                RESP: begin
                    if (rsp) begin
                        remaining <= remaining - 1'b1;
                        cur_addr  <= cur_addr + ADDR_STEP;
                        state     <= last_rsp ? IDLE : REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NDMA_WR_ERR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                        err_o <= 1'b0;
        else if (state == IDLE && start_i)  err_o <= 1'b0;
        else if (rsp && write_mgr.err)      err_o <= 1'b1;
    end
`else
    logic unused_err;
    assign unused_err = write_mgr.err;
`endif

    assign full_o               = fifo_full;
    assign busy_o               = (state != IDLE);
    assign done_o               = done_zero || last_rsp;
    assign write_mgr.req        = req;
    assign write_mgr.addr       = req ? cur_addr : '0;
    assign write_mgr.we         = req;
    assign write_mgr.be         = OBI_BE_WORD;
    assign write_mgr.wdata      = req ? head : '0;
    assign write_mgr.aid        = '0;
    assign write_mgr.a_optional = '0;
endmodule

// File: tb/tb_ndma_write_mgr.sv
// Bench for ndma_write_mgr: OBI subordinate model with address/data
// scoreboards, table-driven transfers and hand-written corner sequences.
`timescale 1ns/1ps
module tb_ndma_write_mgr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] data_in;
    logic        dval;
    logic        full;
    logic        busy;
    logic        done;
`ifdef NDMA_WR_ERR_EN
    logic        err;
`endif

    OBI_BUS bus();

    ndma_write_mgr #(
        .FIFO_DEPTH (4),
        .ADDR_STEP  (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .dst_addr_i   (dst),
        .len_i        (len),
        .data_i       (data_in),
        .data_valid_i (dval),
        .full_o       (full),
        .busy_o       (busy),
        .done_o       (done),
`ifdef NDMA_WR_ERR_EN
        .err_o        (err),
`endif
        .write_mgr    (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          hs_cnt = 0;
    int          rv_cnt = 0;
    int          done_cnt = 0;
    int unsigned gnt_wait = 0;
    int unsigned rv_wait = 0;
    int          err_idx = -1;
    logic [31:0] last_addr = '0;

    typedef struct {
        logic [31:0] dst;
        int unsigned len;
        int unsigned gw;
        int unsigned rw;
        int unsigned pre;
        logic [31:0] seed;
        logic [31:0] exp_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Subordinate model: decides gnt/rvalid on the falling edge for the next rising edge.
    initial begin : responder
        logic        rv_pend;
        logic        stall_chk;
        int unsigned g_cnt;
        int unsigned r_cnt;
        logic [31:0] held_addr;
        logic [31:0] held_data;
        logic [31:0] ea;
        logic [31:0] ed;
        rv_pend = 0; stall_chk = 0; g_cnt = 0; r_cnt = 0;
        held_addr = '0; held_data = '0;
        bus.gnt = 0; bus.rvalid = 0; bus.err = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.gnt = 0; bus.rvalid = 0; bus.err = 0;
                rv_pend = 0; stall_chk = 0; g_cnt = 0; r_cnt = 0;
            end else begin
                if (bus.gnt) begin
                    rv_pend = 1;
                    r_cnt = 0;
                end
                bus.gnt = 0; bus.rvalid = 0; bus.err = 0;
                if (rv_pend) begin
                    if (r_cnt >= rv_wait) begin
                        bus.rvalid = 1;
                        bus.err = (rv_cnt == err_idx);
                        rv_pend = 0;
                        rv_cnt++;
                    end else r_cnt++;
                end
                if (stall_chk) begin
                    check("stall_req_held", bus.req, 1);
                    check("stall_addr", bus.addr, held_addr);
                    check("stall_wdata", bus.wdata, held_data);
                end
                stall_chk = 0;
                if (bus.req) begin
                    if (g_cnt >= gnt_wait) begin
                        bus.gnt = 1;
                        g_cnt = 0;
                        hs_cnt++;
                        last_addr = bus.addr;
                        check("sb_expected", 32'(exp_addr_q.size() != 0 && exp_data_q.size() != 0), 1);
                        if (exp_addr_q.size() != 0 && exp_data_q.size() != 0) begin
                            ea = exp_addr_q.pop_front();
                            ed = exp_data_q.pop_front();
                            check("wr_addr", bus.addr, ea);
                            check("wr_data", bus.wdata, ed);
                        end
                        check("wr_we", bus.we, 1);
                        check("wr_be", bus.be, 4'hF);
                    end else begin
                        g_cnt++;
                        stall_chk = 1;
                        held_addr = bus.addr;
                        held_data = bus.wdata;
                    end
                end
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            #3;
            if (done) done_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] d, input bit accept);
        data_in = d;
        dval = 1;
        if (accept) exp_data_q.push_back(d);
        tick();
        dval = 0;
    endtask

    task automatic start_xfer(input logic [31:0] a, input int unsigned l, input bit accept);
        logic [31:0] lv;
        lv = l;
        dst = a;
        len = lv[15:0];
        start = 1;
        if (accept) for (int unsigned i = 0; i < l; i++) exp_addr_q.push_back(a + 4 * i);
        tick();
        start = 0;
    endtask

    task automatic run_words(input logic [31:0] seed, input int unsigned first,
                             input int unsigned n, input int target, input string name);
        int unsigned idx;
        int unsigned budget;
        idx = first;
        budget = 0;
        while ((idx < n || done_cnt < target) && budget < 400) begin
            if (idx < n && !full) begin
                data_in = seed + idx;
                dval = 1;
                exp_data_q.push_back(seed + idx);
                idx++;
            end else dval = 0;
            tick();
            budget++;
        end
        dval = 0;
        check({name, "_done"}, done_cnt, target);
    endtask

    task automatic wait_count(input int target, input bit use_rv, input string name);
        int unsigned budget;
        budget = 0;
        while ((use_rv ? rv_cnt : hs_cnt) < target && budget < 200) begin
            tick();
            budget++;
        end
        check(name, use_rv ? rv_cnt : hs_cnt, target);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int h0;
        int d0;
        string nm;
        nm = $sformatf("v%0d", k);
        gnt_wait = v.gw;
        rv_wait = v.rw;
        h0 = hs_cnt;
        d0 = done_cnt;
        for (int unsigned i = 0; i < v.pre; i++) push_word(v.seed + i, 1);
        start_xfer(v.dst, v.len, 1);
        run_words(v.seed, v.pre, v.len, d0 + 1, nm);
        check({nm, "_writes"}, hs_cnt - h0, v.len);
        check({nm, "_last_addr"}, last_addr, v.exp_last);
        check({nm, "_busy_end"}, busy, 0);
        check({nm, "_sb_addr_left"}, exp_addr_q.size(), 0);
        check({nm, "_sb_data_left"}, exp_data_q.size(), 0);
    endtask

    initial begin : main
        vec_t vecs[5];
        int   h0;
        int   d0;
        int   r0;
        vecs[0] = '{32'h0000_1000, 3, 0, 0, 0, 32'h0000_000A, 32'h0000_1008};
        vecs[1] = '{32'h0000_2000, 4, 5, 0, 4, 32'h0000_0100, 32'h0000_200C};
        vecs[2] = '{32'hFFFF_FFF8, 4, 1, 2, 2, 32'h0000_0200, 32'h0000_0004};
        vecs[3] = '{32'h0000_0040, 6, 0, 3, 0, 32'h0000_0300, 32'h0000_0054};
        vecs[4] = '{32'h0000_8000, 1, 2, 1, 1, 32'h0000_0400, 32'h0000_8000};

        rst_n = 0; start = 0; dst = '0; len = '0; data_in = '0; dval = 0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        check("rst_req", bus.req, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_aid", bus.aid, 0);
        check("rst_aopt", bus.a_optional, 0);
        rst_n = 1;
        tick();

        // Zero-length transfer
        h0 = hs_cnt;
        d0 = done_cnt;
        start_xfer(32'h0000_5000, 0, 1);
        check("zero_done_pulse", done, 1);
        check("zero_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zero_busy_idle", busy, 0);
            check("zero_req_idle", bus.req, 0);
        end
        check("zero_done_count", done_cnt - d0, 1);
        check("zero_no_writes", hs_cnt - h0, 0);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Backpressure: full before start, 5th word dropped
        gnt_wait = 0; rv_wait = 0;
        d0 = done_cnt;
        for (int unsigned i = 0; i < 4; i++) push_word(32'h0000_0500 + i, 1);
        check("bp_full", full, 1);
        push_word(32'h0000_DEAD, 0);
        check("bp_full_after_drop", full, 1);
        h0 = hs_cnt;
        start_xfer(32'h0000_3000, 4, 1);
        wait_count(h0 + 1, 0, "bp_first_gnt");
        check("bp_not_full_after_gnt", full, 0);
        run_words(32'h0, 4, 4, d0 + 1, "bp");
        check("bp_writes", hs_cnt - h0, 4);
        check("bp_sb_data_left", exp_data_q.size(), 0);

        // Starved FIFO, with a start ignored while busy
        d0 = done_cnt;
        h0 = hs_cnt;
        r0 = rv_cnt;
        start_xfer(32'h0000_6000, 2, 1);
        push_word(32'h0000_0600, 1);
        wait_count(r0 + 1, 1, "starve_first_rsp");
        start_xfer(32'h0000_BAD0, 5, 0);
        for (int i = 0; i < 9; i++) begin
            check("starve_req_low", bus.req, 0);
            check("starve_busy", busy, 1);
            tick();
        end
        run_words(32'h0000_0600, 1, 2, d0 + 1, "starve");
        check("starve_writes", hs_cnt - h0, 2);
        check("starve_last_addr", last_addr, 32'h0000_6004);
        repeat (3) tick();
        check("starve_ignored_start", busy, 0);

        // Reset during RESP with a full FIFO
        rv_wait = 6;
        d0 = done_cnt;
        h0 = hs_cnt;
        start_xfer(32'h0000_7000, 2, 1);
        for (int unsigned i = 0; i < 5; i++) push_word(32'h0000_0700 + i, 1);
        wait_count(h0 + 1, 0, "rst_first_gnt");
        tick();
        check("pre_rst_full", full, 1);
        check("pre_rst_busy", busy, 1);
        rst_n = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_full", full, 0);
        check("midrst_req", bus.req, 0);
        repeat (3) tick();
        exp_addr_q.delete();
        exp_data_q.delete();
        rst_n = 1;
        rv_wait = 0;
        repeat (10) tick();
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", busy, 0);
        run_vec('{32'h0000_9000, 2, 0, 0, 0, 32'h0000_0900, 32'h0000_9004}, 5);

`ifdef NDMA_WR_ERR_EN
        gnt_wait = 0; rv_wait = 0;
        d0 = done_cnt;
        r0 = rv_cnt;
        err_idx = r0 + 1;
        for (int unsigned i = 0; i < 3; i++) push_word(32'h0000_0A00 + i, 1);
        start_xfer(32'h0000_A000, 3, 1);
        check("err_clear_start", err, 0);
        wait_count(r0 + 1, 1, "err_rsp1");
        check("err_after_ok_rsp", err, 0);
        wait_count(r0 + 2, 1, "err_rsp2");
        check("err_set", err, 1);
        run_words(32'h0, 3, 3, d0 + 1, "err");
        check("err_through_done", err, 1);
        err_idx = -1;
        start_xfer(32'h0000_B000, 0, 1);
        check("err_cleared_by_start", err, 0);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ndma_write_mgr.md
Name: ndma_write_mgr

Overview:
- Destination-side stage of the NanoDMA datapath, directly downstream of the read manager.
- Captures each read word, offered with a one-cycle valid qualifier, into a small FIFO.
- Issues one OBI write per word to an incrementing destination address.
- Pulses done when the programmed word count has been acknowledged.

Parameters:
- FIFO_DEPTH, 4: number of 32-bit words buffered between the read and write sides; power of two, minimum 2.
- ADDR_STEP, 4: byte increment applied to the destination address after each acknowledged write.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse; latches dst_addr_i and len_i.
- dst_addr_i  input  32  first destination byte address, word aligned.
- len_i  input  16  number of 32-bit words to write.
- data_i  input  32  word from the read stage.
- data_valid_i  input  1  data_i is valid this cycle; push into FIFO.
- full_o  output  1  FIFO holds FIFO_DEPTH words; upstream must not push.
- busy_o  output  1  a transfer is in progress.
- done_o  output  1  one-cycle pulse when the transfer completes.
- write_mgr  OBI_BUS.Manager  -  OBI manager port: req, addr, we, be, wdata, aid, a_optional out; gnt, rvalid, err in.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - FSM goes to IDLE; FIFO is emptied.
  - Address and remaining-count registers are cleared.
  - busy_o, done_o, full_o, write_mgr.req are all 0.
  - Reset mid-transaction abandons the transfer with no completion pulse.
- FIFO:
  - A push occurs when data_valid_i=1 and the FIFO is not full.
  - A push while full is ignored and the word is lost; the upstream contract is to respect full_o.
  - Pushes are accepted in every state, including IDLE, so the read side may run ahead of start_i.
  - A simultaneous push and pop leaves the occupancy unchanged.
  - full_o is combinational from the occupancy.
- FSM states: IDLE, REQ, RESP.
  - IDLE: on start_i, latch cur_addr=dst_addr_i and remaining=len_i.
    - len_i=0: stay in IDLE, pulse done_o on the next cycle, no bus activity.
    - Otherwise go to REQ; busy_o=1 from the next cycle.
  - REQ: while the FIFO is empty, req=0 and the FSM waits.
    - When the FIFO is non-empty, drive req=1, addr=cur_addr, we=1, be=4'hF and wdata=FIFO head.
    - addr, we, be and wdata are held stable until gnt (OBI rule: no retraction while req=1 without gnt).
    - On req&&gnt: pop the FIFO and go to RESP. Single-cycle grant is allowed; the minimum is one REQ cycle per word.
  - RESP: req=0; wait for rvalid.
    - On rvalid: remaining-=1 and cur_addr+=ADDR_STEP, with 32-bit wrap-around permitted and no boundary check.
    - If remaining was 1: pulse done_o in the same cycle as rvalid, drop busy_o, go to IDLE.
    - Otherwise go to REQ; the next request starts the following cycle.
- start_i while busy_o=1 is ignored.
- At most one outstanding transaction.
- aid and a_optional are always 0; when req=0, addr and wdata are driven 0.

Optional Feature:
- Macro NDMA_WR_ERR_EN.
- Defined:
  - Adds output err_o (1 bit), sticky, set when rvalid&&err in RESP.
  - err_o is cleared by an accepted start_i and by reset.
  - The transfer continues to completion regardless of err.
- Not defined: the err_o port is absent and write_mgr.err is ignored.

Decomposition:
- ndma_pkg (shared package) holds:
  - the write FSM state_t enum;
  - the localparam OBI_BE_WORD=4'hF;
  - the length width constant NDMA_LEN_W=16.
- Sub-module ndma_fifo: parameterised depth/width synchronous FIFO with push, pop, head data, full, empty and async active-low reset; reusable by the read side.

Test Plan:
- Zero-length transfer: start_i with len=0 -> done_o pulses 1 cycle later, req never asserted, busy_o stays 0.
- Basic transfer: dst=0x1000, len=3; push 0xA, 0xB, 0xC; gnt and rvalid each 1 cycle after the previous phase -> writes 0xA@0x1000, 0xB@0x1004, 0xC@0x1008, be=4'hF, done_o on the third rvalid.
- Grant stall: hold gnt=0 for 5 cycles while req=1 -> addr and wdata stable all 5 cycles, FIFO head not popped until gnt.
- Backpressure: FIFO_DEPTH=4, push 4 words before start_i -> full_o=1; a 5th push is ignored; after the first gnt, full_o=0.
- Starved FIFO: len=2, the second word arrives 10 cycles after the first response -> req stays 0 in REQ until the push, then the write completes.
- Reset and error: assert rst_ni low mid-RESP -> all outputs 0 immediately, no done_o. With NDMA_WR_ERR_EN, err=1 on the second of 3 responses -> err_o=1 through done, cleared on the next start_i.
